timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 15 +
 rtl/timer_ctrl_counter.sv | 22 ++
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared FSM state encoding and mode constants for timer_ctrl.
package timer_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter.sv
// Free-running up-counter with synchronous active-low clear; used as the
// timer_ctrl prescaler, so it only exists when TIMER_CTRL_PRESCALER_EN is defined.
`ifdef TIMER_CTRL_PRESCALER_EN
module timer_ctrl_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            COUNT <= '0;
        end else if (EN) begin
            COUNT <= COUNT + WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_ctrl.sv
// Start/stop/pause tick timer with one-shot and periodic expiry, sticky IRQ.
// Optional tick prescaler enabled by defining TIMER_CTRL_PRESCALER_EN.
module timer_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  PAUSE,
    input  logic                  MODE,
    input  logic [WIDTH-1:0]      PERIOD,
`ifdef TIMER_CTRL_PRESCALER_EN
    input  logic [PRESCALE_W-1:0] PRESCALE,
`endif
    input  logic                  IRQ_CLR,
    output logic [WIDTH-1:0]      VALUE,
    output logic                  BUSY,
    output logic                  EXPIRE,
    output logic                  IRQ
);

    import timer_ctrl_pkg::*;

    if (WIDTH < 2 || WIDTH > 64 || PRESCALE_W < 1) begin : g_bad_param
        $error("timer_ctrl: WIDTH must be 2..64 and PRESCALE_W at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] value_d;
    logic             mode_q, mode_d;
    logic             busy_d, expire_d, irq_d;
    logic             start_ok, tick, wrap;

    // A START with a zero period is treated as if it never happened.
    assign start_ok = START && (PERIOD != '0);

`ifdef TIMER_CTRL_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  run_c;
    logic                  pre_rstn;

    assign run_c    = (state_q == RUN);
    assign tick     = run_c && (pre_cnt == prescale_q);
    assign pre_rstn = !(RST || start_ok || STOP || tick);

    timer_ctrl_counter #(
        .WIDTH (PRESCALE_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RSTN  (pre_rstn),
        .EN    (run_c),
        .COUNT (pre_cnt)
    );
`else
    assign tick = (state_q == RUN);
`endif

    assign wrap = tick && (VALUE == (period_q - WIDTH'(1)));

    // Next-state and next-output logic; STOP beats START, expiry always reports.
    always_comb begin
        state_d    = state_q;
        value_d    = VALUE;
        period_d   = period_q;
        mode_d     = mode_q;
        expire_d   = 1'b0;
        irq_d      = IRQ && !IRQ_CLR;
`ifdef TIMER_CTRL_PRESCALER_EN
        prescale_d = prescale_q;
`endif

        if (tick) begin
            value_d = wrap ? '0 : (VALUE + WIDTH'(1));
        end
        if (wrap) begin
            expire_d = 1'b1;
            irq_d    = 1'b1;
        end

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                if (wrap && (mode_q == MODE_ONESHOT)) begin
                    state_d = IDLE;
                end else if (PAUSE) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!PAUSE) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (STOP) begin
            state_d = IDLE;
        end else if (start_ok) begin
            state_d    = RUN;
            value_d    = '0;
            period_d   = PERIOD;
            mode_d     = MODE;
`ifdef TIMER_CTRL_PRESCALER_EN
            prescale_d = PRESCALE;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            VALUE      <= '0;
            period_q   <= '0;
            mode_q     <= MODE_ONESHOT;
            BUSY       <= 1'b0;
            EXPIRE     <= 1'b0;
            IRQ        <= 1'b0;
`ifdef TIMER_CTRL_PRESCALER_EN
            prescale_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            VALUE      <= value_d;
            period_q   <= period_d;
            mode_q     <= mode_d;
            BUSY       <= busy_d;
            EXPIRE     <= expire_d;
            IRQ        <= irq_d;
`ifdef TIMER_CTRL_PRESCALER_EN
            prescale_q <= prescale_d;
`endif
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl; the prescaler scenario is
// included only when TIMER_CTRL_PRESCALER_EN is defined.
module tb_timer_ctrl;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned PRESCALE_W = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  START;
    logic                  STOP;
    logic                  PAUSE;
    logic                  MODE;
    logic [WIDTH-1:0]      PERIOD;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  IRQ_CLR;
    logic [WIDTH-1:0]      VALUE;
    logic                  BUSY;
    logic                  EXPIRE;
    logic                  IRQ;

    int tests = 0;
    int fails = 0;

    timer_ctrl #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .STOP     (STOP),
        .PAUSE    (PAUSE),
        .MODE     (MODE),
        .PERIOD   (PERIOD),
`ifdef TIMER_CTRL_PRESCALER_EN
        .PRESCALE (PRESCALE),
`endif
        .IRQ_CLR  (IRQ_CLR),
        .VALUE    (VALUE),
        .BUSY     (BUSY),
        .EXPIRE   (EXPIRE),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        tests++;
        if (VALUE !== 16'd0) begin fails++; $display("FAIL reset_value: got %0d want 0", VALUE); end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        tests++;
        if (EXPIRE !== 1'b0) begin fails++; $display("FAIL reset_expire: got %b want 0", EXPIRE); end
        tests++;
        if (IRQ !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        logic [15:0] ev;
        logic        ee, eb, ei;
        PERIOD = 16'd4; MODE = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            ev = (c <= 4) ? 16'(c - 1) : 16'd0;
            ee = (c == 5);
            eb = (c <= 4);
            ei = (c >= 5);
            tests++;
            if (VALUE !== ev || EXPIRE !== ee || BUSY !== eb || IRQ !== ei) begin
                fails++;
                $display("FAIL oneshot c%0d: VALUE=%0d EXPIRE=%b BUSY=%b IRQ=%b want %0d %b %b %b",
                         c, VALUE, EXPIRE, BUSY, IRQ, ev, ee, eb, ei);
            end
            step();
        end
        IRQ_CLR = 1'b1;
        step();
        IRQ_CLR = 1'b0;
        tests++;
        if (IRQ !== 1'b0) begin fails++; $display("FAIL oneshot_irq_clr: got %b want 0", IRQ); end
    endtask

    task automatic test_periodic();
        logic [15:0] ev;
        logic        ee;
        PERIOD = 16'd3; MODE = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            ev = 16'((c - 1) % 3);
            ee = (c >= 4) && ((c - 1) % 3 == 0);
            tests++;
            if (VALUE !== ev || EXPIRE !== ee || BUSY !== 1'b1) begin
                fails++;
                $display("FAIL periodic c%0d: VALUE=%0d EXPIRE=%b BUSY=%b want %0d %b 1",
                         c, VALUE, EXPIRE, BUSY, ev, ee);
            end
            if (c == 10) STOP = 1'b1;
            step();
            STOP = 1'b0;
        end
        // The tick in the STOP cycle still lands, then VALUE holds in IDLE.
        step();
        tests++;
        if (VALUE !== 16'd1 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL periodic_stop_hold: VALUE=%0d BUSY=%b want 1 0", VALUE, BUSY);
        end
    endtask

    task automatic test_pause();
        logic [15:0] ev;
        logic        ee, eb;
        PERIOD = 16'd8; MODE = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c <= 2)       ev = 16'(c - 1);
            else if (c <= 8)  ev = 16'd2;
            else if (c <= 13) ev = 16'(c - 6);
            else              ev = 16'd0;
            ee = (c == 14);
            eb = (c <= 13);
            tests++;
            if (VALUE !== ev || EXPIRE !== ee || BUSY !== eb) begin
                fails++;
                $display("FAIL pause c%0d: VALUE=%0d EXPIRE=%b BUSY=%b want %0d %b %b",
                         c, VALUE, EXPIRE, BUSY, ev, ee, eb);
            end
            PAUSE = (c >= 2) && (c <= 6);
            step();
        end
        PAUSE = 1'b0;
    endtask

    task automatic test_start_stop();
        PERIOD = 16'd5; MODE = 1'b1; START = 1'b1; STOP = 1'b1;
        step();
        START = 1'b0; STOP = 1'b0;
        tests++;
        if (BUSY !== 1'b0 || VALUE !== 16'd0) begin
            fails++;
            $display("FAIL start_stop_same: BUSY=%b VALUE=%0d want 0 0", BUSY, VALUE);
        end
        PERIOD = 16'd10; START = 1'b1;
        step();
        START = 1'b0;
        repeat (5) step();
        tests++;
        if (VALUE !== 16'd5 || BUSY !== 1'b1 || IRQ !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: VALUE=%0d BUSY=%b IRQ=%b want 5 1 1", VALUE, BUSY, IRQ);
        end
        RST = 1'b1;
        step();
        tests++;
        if (VALUE !== 16'd0 || BUSY !== 1'b0 || EXPIRE !== 1'b0 || IRQ !== 1'b0) begin
            fails++;
            $display("FAIL reset_midcount: VALUE=%0d BUSY=%b EXPIRE=%b IRQ=%b want 0 0 0 0",
                     VALUE, BUSY, EXPIRE, IRQ);
        end
        START = 1'b1; PERIOD = 16'd1;
        step();
        START = 1'b0; RST = 1'b0;
        tests++;
        if (BUSY !== 1'b0 || EXPIRE !== 1'b0) begin
            fails++;
            $display("FAIL reset_over_start: BUSY=%b EXPIRE=%b want 0 0", BUSY, EXPIRE);
        end
        step();
        tests++;
        if (BUSY !== 1'b0 || EXPIRE !== 1'b0 || VALUE !== 16'd0) begin
            fails++;
            $display("FAIL reset_exit: BUSY=%b EXPIRE=%b VALUE=%0d want 0 0 0", BUSY, EXPIRE, VALUE);
        end
    endtask

    task automatic test_irq_clr();
        PERIOD = 16'd3; MODE = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        tests++;
        if (IRQ !== 1'b1 || EXPIRE !== 1'b1) begin
            fails++;
            $display("FAIL irq_first_set: IRQ=%b EXPIRE=%b want 1 1", IRQ, EXPIRE);
        end
        repeat (2) step();
        IRQ_CLR = 1'b1;
        step();
        IRQ_CLR = 1'b0;
        tests++;
        if (IRQ !== 1'b1 || EXPIRE !== 1'b1) begin
            fails++;
            $display("FAIL irq_set_beats_clr: IRQ=%b EXPIRE=%b want 1 1", IRQ, EXPIRE);
        end
        step();
        IRQ_CLR = 1'b1;
        step();
        IRQ_CLR = 1'b0;
        tests++;
        if (IRQ !== 1'b0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL irq_clr_alone: IRQ=%b BUSY=%b want 0 1", IRQ, BUSY);
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
    endtask

    task automatic test_restart();
        logic [15:0] ev;
        logic        ee, eb;
        PERIOD = 16'd10; MODE = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 5)      ev = 16'(c - 1);
            else if (c == 7) ev = 16'd1;
            else             ev = 16'd0;
            ee = (c == 8);
            eb = (c <= 7);
            tests++;
            if (VALUE !== ev || EXPIRE !== ee || BUSY !== eb) begin
                fails++;
                $display("FAIL restart c%0d: VALUE=%0d EXPIRE=%b BUSY=%b want %0d %b %b",
                         c, VALUE, EXPIRE, BUSY, ev, ee, eb);
            end
            if (c == 3) begin START = 1'b1; PERIOD = 16'd0; end
            if (c == 5) begin START = 1'b1; PERIOD = 16'd2; MODE = 1'b0; end
            step();
            START = 1'b0;
        end
    endtask

`ifdef TIMER_CTRL_PRESCALER_EN
    task automatic test_prescaler();
        logic [15:0] ev;
        logic        ee;
        PRESCALE = 4'd2; PERIOD = 16'd2; MODE = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ev = (c >= 4 && c <= 6) ? 16'd1 : 16'd0;
            ee = (c == 7);
            tests++;
            if (VALUE !== ev || EXPIRE !== ee || BUSY !== (c <= 6)) begin
                fails++;
                $display("FAIL prescaler c%0d: VALUE=%0d EXPIRE=%b BUSY=%b want %0d %b %b",
                         c, VALUE, EXPIRE, BUSY, ev, ee, (c <= 6));
            end
            step();
        end
    endtask
`endif

    initial begin
        RST = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; MODE = 1'b0;
        PERIOD = '0; PRESCALE = '0; IRQ_CLR = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_start_stop();
        test_irq_clr();
        test_restart();
`ifdef TIMER_CTRL_PRESCALER_EN
        test_prescaler();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
